// File: rtl/cdb_wb_arbiter_if.sv
// cdb_wb_arbiter_if: functional-unit result handshake and CDB broadcast.
// The master side drives results; the slave (arbiter) side broadcasts.
interface cdb_wb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 5,
  parameter int REG_W     = 5
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*REG_W-1:0]     req_rd_addr;
  logic                         cdb_valid;
  logic [DATA_W-1:0]            cdb_data;
  logic [ROB_IDX_W-1:0]         cdb_rob_idx;
  logic [REG_W-1:0]             cdb_rd_addr;
  logic                         cdb_regf_we;
  logic [NUM_REQ-1:0]           cdb_src;

  modport master (
    output req_valid, req_data,
    output req_rob_idx, req_rd_addr,
    input  req_ready,
    input  cdb_valid, cdb_data,
    input  cdb_rob_idx, cdb_rd_addr,
    input  cdb_regf_we, cdb_src
  );

  modport slave (
    input  req_valid, req_data,
    input  req_rob_idx, req_rd_addr,
    output req_ready,
    output cdb_valid, cdb_data,
    output cdb_rob_idx, cdb_rd_addr,
    output cdb_regf_we, cdb_src
  );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter: round-robin writeback arbiter onto the CDB.
// One-entry buffer per unit feeding a registered one-cycle broadcast.
module cdb_wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 5,
  parameter int REG_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  cdb_wb_arbiter_if.slave bus,
  output logic [31:0]     stall_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   buf_valid;
  logic [NUM_REQ-1:0]   grant;
  logic [DATA_W-1:0]    buf_data [NUM_REQ];
  logic [ROB_IDX_W-1:0] buf_rob  [NUM_REQ];
  logic [REG_W-1:0]     buf_rd   [NUM_REQ];
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     rr_next;
  logic [31:0]          stall_q;
  logic                 stall;

  always_comb begin
    int  j;
    logic found;
    grant = '0;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && buf_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win      = PTR_W'(j);
      end
    end
  end

  assign rr_next = (int'(win) == NUM_REQ - 1) ?
                   '0 : win + PTR_W'(1);

  // a draining buffer can be refilled in the same cycle
  assign bus.req_ready = {NUM_REQ{~flush}} &
                         (~buf_valid | grant);

  assign stall = (|(buf_valid & ~grant)) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_data[i] <= '0;
        buf_rob[i]  <= '0;
        buf_rd[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush) begin
          buf_valid[i] <= 1'b0;
        end else if (bus.req_valid[i] &&
                     bus.req_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
          buf_rob[i]   <= bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
          buf_rd[i]    <= bus.req_rd_addr[i*REG_W +: REG_W];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      stall_q         <= '0;
      bus.cdb_valid   <= 1'b0;
      bus.cdb_src     <= '0;
      bus.cdb_data    <= '0;
      bus.cdb_rob_idx <= '0;
      bus.cdb_rd_addr <= '0;
    end else begin
      if (stall) stall_q <= stall_q + 32'd1;
      if (flush) begin
        rr_ptr        <= '0;
        bus.cdb_valid <= 1'b0;
        bus.cdb_src   <= '0;
      end else begin
        bus.cdb_valid <= |grant;
        bus.cdb_src   <= grant;
        if (|grant) begin
          rr_ptr          <= rr_next;
          bus.cdb_data    <= buf_data[win];
          bus.cdb_rob_idx <= buf_rob[win];
          bus.cdb_rd_addr <= buf_rd[win];
        end
      end
    end
  end

  assign bus.cdb_regf_we = bus.cdb_valid &&
                           (bus.cdb_rd_addr != '0);
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// tb_cdb_wb_arbiter: directed stimulus with a scoreboard queue
// drained by an independent CDB monitor.
module tb_cdb_wb_arbiter;
  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rob;
    logic [4:0]  rd;
  } item_t;

  typedef struct packed {
    item_t      it;
    logic [3:0] src;
    logic       we;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] stall_cnt;

  int    checks;
  int    errors;
  int    run_len;
  int    max_run;
  int    nrdy1;
  item_t uq [4][$];
  item_t pend [4];
  logic [3:0]  pend_v;
  logic [3:0]  last_rdy;
  logic [31:0] s0;
  exp_t  exp_q [$];
  exp_t  mon_e;

  cdb_wb_arbiter_if #(
    .NUM_REQ(4), .DATA_W(32),
    .ROB_IDX_W(5), .REG_W(5)
  ) bus ();

  cdb_wb_arbiter #(
    .NUM_REQ(4), .DATA_W(32),
    .ROB_IDX_W(5), .REG_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic offer(input int u, input logic [31:0] d,
                       input logic [4:0] rob,
                       input logic [4:0] rd);
    item_t it;
    it.d = d; it.rob = rob; it.rd = rd;
    uq[u].push_back(it);
  endtask

  task automatic expect_beat(input int u, input logic [31:0] d,
                             input logic [4:0] rob,
                             input logic [4:0] rd);
    exp_t e;
    e.it.d = d; e.it.rob = rob; e.it.rd = rd;
    e.src = 4'(1 << u);
    e.we  = (rd != 5'd0);
    exp_q.push_back(e);
  endtask

  function automatic logic busy();
    logic b;
    b = (pend_v != 4'd0);
    for (int i = 0; i < 4; i++)
      if (uq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  // one clock: drive at negedge, note ready, retire accepted offers
  task automatic cycle(input logic fl);
    for (int i = 0; i < 4; i++) begin
      if (!pend_v[i] && uq[i].size() > 0) begin
        pend[i]   = uq[i].pop_front();
        pend_v[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]             = pend_v[i];
      bus.req_data[i*32 +: 32]     = pend[i].d;
      bus.req_rob_idx[i*5 +: 5]    = pend[i].rob;
      bus.req_rd_addr[i*5 +: 5]    = pend[i].rd;
    end
    flush = fl;
    #1;
    last_rdy = bus.req_ready;
    if (pend_v[1] && !last_rdy[1]) nrdy1++;
    @(posedge clk);
    pend_v = pend_v & ~last_rdy;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (busy() && n < bound) begin
      cycle(1'b0);
      n++;
    end
    chk("drain_done", 32'(busy()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.cdb_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got src=%b data=%h, want none",
                 bus.cdb_src, bus.cdb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.cdb_data !== mon_e.it.d ||
            bus.cdb_rob_idx !== mon_e.it.rob ||
            bus.cdb_rd_addr !== mon_e.it.rd ||
            bus.cdb_src !== mon_e.src ||
            bus.cdb_regf_we !== mon_e.we) begin
          errors++;
          $display("FAIL cdb_beat: got src=%b d=%h rob=%0d rd=%0d we=%b want src=%b d=%h rob=%0d rd=%0d we=%b",
                   bus.cdb_src, bus.cdb_data, bus.cdb_rob_idx,
                   bus.cdb_rd_addr, bus.cdb_regf_we,
                   mon_e.src, mon_e.it.d, mon_e.it.rob,
                   mon_e.it.rd, mon_e.we);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    checks = 0; errors = 0;
    run_len = 0; max_run = 0; nrdy1 = 0;
    pend_v = '0; last_rdy = '0;
    for (int i = 0; i < 4; i++) pend[i] = '0;
    rst_n = 1'b0; flush = 1'b0;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_rob_idx = '0;
    bus.req_rd_addr = '0;

    // power-on reset
    repeat (3) @(negedge clk);
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'hF);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_src", 32'(bus.cdb_src), 32'd0);
    chk("rst_data", bus.cdb_data, 32'd0);
    rst_n = 1'b1;

    // round robin, all units busy from reset
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin
        offer(i, 32'hB000_0000 | (i << 8) | k,
              5'(i*4 + k), 5'(i*3 + k + 1));
        expect_beat(i, 32'hB000_0000 | (i << 8) | k,
                    5'(i*4 + k), 5'(i*3 + k + 1));
      end
    cycle(1'b0);
    cycle(1'b0);
    chk("rr_stall_first", stall_cnt, 32'd1);
    drain(60);
    idle(6);
    chk("rr_stall_total", stall_cnt, 32'd11);

    // single-unit latency
    offer(0, 32'hDEAD_BEEF, 5'd3, 5'd7);
    expect_beat(0, 32'hDEAD_BEEF, 5'd3, 5'd7);
    cycle(1'b0);
    chk("lat_cycle1_valid", 32'(bus.cdb_valid), 32'd0);
    cycle(1'b0);
    chk("lat_cycle2_valid", 32'(bus.cdb_valid), 32'd1);
    chk("lat_cycle2_we", 32'(bus.cdb_regf_we), 32'd1);
    chk("lat_cycle2_src", 32'(bus.cdb_src), 32'h1);
    idle(3);

    // back-to-back stream on unit 1
    max_run = 0; nrdy1 = 0; s0 = stall_cnt;
    for (int k = 0; k < 5; k++) begin
      offer(1, 32'hD100_0000 + k, 5'(16 + k), 5'(k + 1));
      expect_beat(1, 32'hD100_0000 + k, 5'(16 + k), 5'(k + 1));
    end
    drain(20);
    idle(4);
    chk("b2b_ready_drops", nrdy1, 32'd0);
    chk("b2b_run_len", max_run, 32'd5);
    chk("b2b_no_stall", stall_cnt, s0);

    // flush with buffers 0 and 2 full, unit 3 requesting
    offer(0, 32'hE0, 5'd10, 5'd10);
    offer(2, 32'hE2, 5'd12, 5'd12);
    cycle(1'b0);
    offer(3, 32'hE3, 5'd13, 5'd13);
    cycle(1'b1);
    chk("flush_u3_ready", 32'(last_rdy[3]), 32'd0);
    chk("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    #1;
    chk("flush_bufs_empty", 32'(bus.req_ready), 32'hF);
    offer(1, 32'hE1, 5'd11, 5'd11);
    expect_beat(1, 32'hE1, 5'd11, 5'd11);
    expect_beat(3, 32'hE3, 5'd13, 5'd13);
    drain(10);
    idle(4);

    // rd=0 still broadcasts, no regfile write
    offer(2, 32'h1234_5678, 5'd9, 5'd0);
    expect_beat(2, 32'h1234_5678, 5'd9, 5'd0);
    drain(10);
    idle(4);

    // stall counter wrap
    force dut.stall_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_q;
    chk("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
    offer(0, 32'h60, 5'd1, 5'd31);
    offer(1, 32'h61, 5'd2, 5'd30);
    expect_beat(0, 32'h60, 5'd1, 5'd31);
    expect_beat(1, 32'h61, 5'd2, 5'd30);
    drain(10);
    idle(3);
    chk("stall_wrap", stall_cnt, 32'd0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++)
      offer(i, 32'hA0 + i, 5'(20 + i), 5'(i + 1));
    expect_beat(2, 32'hA2, 5'd22, 5'd3);
    cycle(1'b0);
    cycle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'hF);
    chk("arst_stall", stall_cnt, 32'd0);
    chk("arst_src", 32'(bus.cdb_src), 32'd0);
    bus.req_valid = '0;
    pend_v = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
